// File: rtl/sap_obi_rr_arbiter.sv
// Round-robin N-to-1 OBI arbiter with an in-order master-ID FIFO (depth MAX_OUTSTANDING); zero added latency on req/gnt and rvalid/rdata.
// Backpressure: no request is issued while the FIFO is full. `define SAP_OBI_ARB_PERF_EN adds per-master grant counters.
module sap_obi_rr_arbiter #(
  parameter type obi_req_t = struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  },
  parameter type obi_resp_t = struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  },
  parameter int XBAR_NMASTER    = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [XBAR_NMASTER],
  output obi_resp_t master_resp_o [XBAR_NMASTER],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o,
  output logic      err_o
`ifdef SAP_OBI_ARB_PERF_EN
  ,
  input  logic        perf_clr_i,
  output logic [31:0] perf_gnt_cnt_o [XBAR_NMASTER]
`endif
);

  localparam int IdW  = (XBAR_NMASTER > 2) ? $clog2(XBAR_NMASTER) : 1;
  localparam int PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {S_IDLE, S_LOCKED} lock_state_e;

  lock_state_e      r_state;
  logic [IdW-1:0]   r_lock_id;
  logic [IdW-1:0]   r_rr_ptr;
  logic [IdW-1:0]   r_fifo [MAX_OUTSTANDING];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             r_err;

  logic [IdW-1:0]   w_sel;
  logic             w_any;
  logic             w_accept;
  logic             w_req;
  logic             w_hs;
  logic             w_pop;
  logic [IdW-1:0]   w_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reverse scan so the lowest offset from r_rr_ptr wins without a break.
  always_comb begin
    int idx;
    w_sel = r_rr_ptr;
    w_any = 1'b0;
    for (int k = XBAR_NMASTER - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % XBAR_NMASTER;
      if (master_req_i[idx].req) begin
        w_sel = IdW'(idx);
        w_any = 1'b1;
      end
    end
    if (r_state == S_LOCKED) begin
      w_sel = r_lock_id;
      w_any = master_req_i[r_lock_id].req;
    end
  end

  assign w_accept = (r_cnt < CntW'(MAX_OUTSTANDING));
  assign w_req    = w_any & w_accept;
  assign w_hs     = w_req & slave_resp_i.gnt;
  assign w_pop    = slave_resp_i.rvalid & (r_cnt != '0);
  assign w_head   = r_fifo[r_rptr];

  always_comb begin
    slave_req_o = '0;
    if (w_any) slave_req_o = master_req_i[w_sel];
    slave_req_o.req = w_req;
  end

  always_comb begin
    for (int i = 0; i < XBAR_NMASTER; i++) begin
      master_resp_o[i] = '0;
      if (w_hs && (w_sel == IdW'(i))) master_resp_o[i].gnt = 1'b1;
      if (w_pop && (w_head == IdW'(i))) begin
        master_resp_o[i].rvalid = 1'b1;
        master_resp_o[i].rdata  = slave_resp_i.rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= ptr_inc(r_wptr);
        r_rr_ptr       <= (w_sel == IdW'(XBAR_NMASTER - 1)) ? '0 : w_sel + 1'b1;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (slave_resp_i.rvalid && (r_cnt == '0)) r_err <= 1'b1;
      // Lock holds the slave request stable until it is granted.
      case (r_state)
        S_IDLE: begin
          if (w_req && !slave_resp_i.gnt) begin
            r_state   <= S_LOCKED;
            r_lock_id <= w_sel;
          end
        end
        S_LOCKED: begin
          if (!master_req_i[r_lock_id].req) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (r_cnt != '0);
  assign err_o  = r_err;

`ifdef SAP_OBI_ARB_PERF_EN
  logic [31:0] r_perf_cnt [XBAR_NMASTER];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < XBAR_NMASTER; i++) begin
      if (rst_i || perf_clr_i)               r_perf_cnt[i] <= '0;
      else if (w_hs && (w_sel == IdW'(i)))   r_perf_cnt[i] <= r_perf_cnt[i] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < XBAR_NMASTER; i++) perf_gnt_cnt_o[i] = r_perf_cnt[i];
  end
`endif

endmodule

// File: tb/tb_sap_obi_rr_arbiter.sv
// Randomized bench for sap_obi_rr_arbiter against a queue-based transaction model.
module tb_sap_obi_rr_arbiter;
  localparam int N    = 3;
  localparam int MAXO = 2;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst;
  req_t  mreq  [N];
  resp_t mresp [N];
  req_t  sreq;
  resp_t sresp;
  logic  busy, err;
`ifdef SAP_OBI_ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_cnt [N];
  int unsigned m_pcnt   [N];
`endif

  always #5 clk = ~clk;

  sap_obi_rr_arbiter #(
    .obi_req_t(req_t), .obi_resp_t(resp_t),
    .XBAR_NMASTER(N), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .master_req_i(mreq), .master_resp_o(mresp),
    .slave_req_o(sreq), .slave_resp_i(sresp),
    .busy_o(busy), .err_o(err)
`ifdef SAP_OBI_ARB_PERF_EN
    , .perf_clr_i(perf_clr), .perf_gnt_cnt_o(perf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: round-robin pointer, ID queue, lock and error flags.
  int m_rr;
  int m_q [$];
  bit m_lock;
  int m_lock_id;
  bit m_err;
  bit hold [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: clean random, 1: random with resets and protocol drops,
  // 2: no new requests, rvalid with rdata DEADBEEF, 3: idle.
  task automatic step(input int mode);
    bit any, exp_sreq, hs, popv;
    int sel;
    @(negedge clk);
    rst = (mode == 1) && ($urandom_range(0, 39) == 0);
    for (int i = 0; i < N; i++) begin
      if (hold[i]) begin
        if (mode == 1 && $urandom_range(0, 29) == 0) mreq[i].req = 1'b0;
      end else if (mode <= 1) begin
        mreq[i].req   = 1'($urandom_range(0, 1));
        mreq[i].we    = 1'($urandom_range(0, 1));
        mreq[i].be    = 4'($urandom);
        mreq[i].addr  = $urandom;
        mreq[i].wdata = $urandom;
      end else begin
        mreq[i] = '0;
      end
    end
    sresp.gnt   = (mode <= 1) ? ($urandom_range(0, 99) < 60) : 1'b0;
    sresp.rdata = (mode == 2) ? 32'hDEADBEEF : $urandom;
    case (mode)
      0:       sresp.rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      1:       sresp.rvalid = ($urandom_range(0, 3) == 0);
      2:       sresp.rvalid = 1'b1;
      default: sresp.rvalid = 1'b0;
    endcase
    #1;

    any = 1'b0;
    sel = m_rr;
    if (m_lock) begin
      sel = m_lock_id;
      any = mreq[sel].req;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!any && mreq[(m_rr + k) % N].req) begin
          any = 1'b1;
          sel = (m_rr + k) % N;
        end
      end
    end
    exp_sreq = any && (m_q.size() < MAXO);
    hs   = exp_sreq && sresp.gnt;
    popv = sresp.rvalid && (m_q.size() > 0);

    check_eq("sreq", 64'(sreq.req), 64'(exp_sreq));
    if (any) begin
      check_eq("saddr", 64'(sreq.addr), 64'(mreq[sel].addr));
      check_eq("swdata", 64'({sreq.we, sreq.be, sreq.wdata}), 64'({mreq[sel].we, mreq[sel].be, mreq[sel].wdata}));
    end else begin
      check_eq("sidle", 64'(sreq == '0), 64'd1);
    end
    for (int i = 0; i < N; i++) begin
      bit rv_i;
      rv_i = popv && (m_q[0] == i);
      check_eq($sformatf("gnt%0d", i), 64'(mresp[i].gnt), 64'(hs && (sel == i)));
      check_eq($sformatf("rvalid%0d", i), 64'(mresp[i].rvalid), 64'(rv_i));
      check_eq($sformatf("rdata%0d", i), 64'(mresp[i].rdata), rv_i ? 64'(sresp.rdata) : 64'd0);
`ifdef SAP_OBI_ARB_PERF_EN
      check_eq($sformatf("perf%0d", i), 64'(perf_cnt[i]), 64'(m_pcnt[i]));
`endif
    end
    check_eq("busy", 64'(busy), 64'(m_q.size() != 0));
    check_eq("err", 64'(err), 64'(m_err));

    for (int i = 0; i < N; i++) hold[i] = mreq[i].req && !(hs && (sel == i));
    if (rst) begin
      m_q.delete();
      m_rr   = 0;
      m_lock = 1'b0;
      m_err  = 1'b0;
`ifdef SAP_OBI_ARB_PERF_EN
      for (int i = 0; i < N; i++) m_pcnt[i] = 0;
`endif
    end else begin
      if (sresp.rvalid && m_q.size() == 0) m_err = 1'b1;
      if (m_lock) begin
        if (!mreq[m_lock_id].req) begin
          m_err  = 1'b1;
          m_lock = 1'b0;
        end else if (hs) begin
          m_lock = 1'b0;
        end
      end else if (exp_sreq && !sresp.gnt) begin
        m_lock    = 1'b1;
        m_lock_id = sel;
      end
      if (popv) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(sel);
        m_rr = (sel + 1) % N;
`ifdef SAP_OBI_ARB_PERF_EN
        m_pcnt[sel]++;
`endif
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    sresp = '0;
    for (int i = 0; i < N; i++) begin
      mreq[i] = '0;
      hold[i] = 1'b0;
`ifdef SAP_OBI_ARB_PERF_EN
      m_pcnt[i] = 0;
`endif
    end
`ifdef SAP_OBI_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);

    step(3);
    step(3);
    repeat (600) step(0);
    repeat (5) step(2);
    repeat (2) step(3);
    repeat (400) step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
